// File: rtl/lsu_rdata_buf.sv
// Load read-response buffer: records per-load format metadata, formats memory read data and queues results in order.
// Optional error tracking per result is enabled by defining LSU_RDATA_ERR_EN.
module lsu_rdata_buf #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_type_i,
  input  logic              req_sign_i,
  input  logic [1:0]        req_offset_i,
  input  logic              data_rvalid_i,
  input  logic [DATA_W-1:0] data_rdata_i,
`ifdef LSU_RDATA_ERR_EN
  input  logic              data_err_i,
  output logic              lsu_err_o,
`endif
  output logic              lsu_rvalid_o,
  input  logic              lsu_rready_i,
  output logic [31:0]       lsu_rdata_o,
  output logic              spurious_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [1:0] ltype;
    logic       sign;
    logic [1:0] offset;
  } meta_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  meta_t            r_m_mem [DEPTH];
  logic [31:0]      r_r_mem [DEPTH];
  logic [PTR_W-1:0] r_m_wr, r_m_rd, r_r_wr, r_r_rd;
  logic [CNT_W-1:0] r_m_cnt, r_r_cnt;
  logic             r_req_ready, r_rvalid, r_spurious;
  logic [31:0]      r_rdata;

  logic             w_push, w_resp, w_pop;
  logic [CNT_W-1:0] w_m_cnt_nxt, w_r_cnt_nxt, w_r_rem;
  logic [SUM_W-1:0] w_inflight_nxt;
  logic [PTR_W-1:0] w_r_rd_nxt;
  meta_t            w_head;
  logic [31:0]      w_rdata, w_fmt, w_wdata;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;

  assign w_push = req_valid_i & r_req_ready;
  assign w_resp = data_rvalid_i & (r_m_cnt != '0);
  assign w_pop  = r_rvalid & lsu_rready_i;

  assign w_m_cnt_nxt    = r_m_cnt + CNT_W'(w_push) - CNT_W'(w_resp);
  assign w_r_cnt_nxt    = r_r_cnt + CNT_W'(w_resp) - CNT_W'(w_pop);
  assign w_inflight_nxt = SUM_W'(w_m_cnt_nxt) + SUM_W'(w_r_cnt_nxt);

  // Entries left in R once this cycle's pop is taken; selects the next output head
  assign w_r_rem    = r_r_cnt - CNT_W'(w_pop);
  assign w_r_rd_nxt = w_pop ? ptr_inc(r_r_rd) : r_r_rd;

  assign w_head  = r_m_mem[r_m_rd];
  assign w_rdata = 32'(data_rdata_i);

  // Lane select and sign/zero extension for the oldest pending load
  always_comb begin
    w_byte = w_rdata[7:0];
    w_half = w_head.offset[1] ? w_rdata[31:16] : w_rdata[15:0];
    w_fmt  = w_rdata;
    case (w_head.offset)
      2'd1:    w_byte = w_rdata[15:8];
      2'd2:    w_byte = w_rdata[23:16];
      2'd3:    w_byte = w_rdata[31:24];
      default: w_byte = w_rdata[7:0];
    endcase
    case (w_head.ltype)
      2'b00:   w_fmt = {{24{w_head.sign & w_byte[7]}}, w_byte};
      2'b01:   w_fmt = {{16{w_head.sign & w_half[15]}}, w_half};
      default: w_fmt = w_rdata;
    endcase
  end

`ifdef LSU_RDATA_ERR_EN
  logic r_r_err [DEPTH];
  logic r_err;

  assign w_wdata   = data_err_i ? '0 : w_fmt;
  assign lsu_err_o = r_err;

  always_ff @(posedge clk_i) begin
    if (w_resp) r_r_err[r_r_wr] <= data_err_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                r_err <= 1'b0;
    else if (w_r_rem != '0)     r_err <= r_r_err[w_r_rd_nxt];
    else if (w_resp)            r_err <= data_err_i;
  end
`else
  assign w_wdata = w_fmt;
`endif

  // FIFO storage; contents are only observed through valid pointers
  always_ff @(posedge clk_i) begin
    if (w_push) r_m_mem[r_m_wr] <= '{ltype: req_type_i, sign: req_sign_i, offset: req_offset_i};
    if (w_resp) r_r_mem[r_r_wr] <= w_wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_m_wr      <= '0;
      r_m_rd      <= '0;
      r_r_wr      <= '0;
      r_r_rd      <= '0;
      r_m_cnt     <= '0;
      r_r_cnt     <= '0;
      r_req_ready <= 1'b1;
      r_rvalid    <= 1'b0;
      r_spurious  <= 1'b0;
      r_rdata     <= '0;
    end else begin
      if (w_push) r_m_wr <= ptr_inc(r_m_wr);
      if (w_resp) begin
        r_m_rd <= ptr_inc(r_m_rd);
        r_r_wr <= ptr_inc(r_r_wr);
      end
      r_r_rd      <= w_r_rd_nxt;
      r_m_cnt     <= w_m_cnt_nxt;
      r_r_cnt     <= w_r_cnt_nxt;
      r_req_ready <= (w_inflight_nxt < SUM_W'(DEPTH));
      r_rvalid    <= (w_r_cnt_nxt != '0);
      r_spurious  <= data_rvalid_i & (r_m_cnt == '0);
      // Output holds its last value when R drains
      if (w_r_rem != '0)  r_rdata <= r_r_mem[w_r_rd_nxt];
      else if (w_resp)    r_rdata <= w_wdata;
    end
  end

  assign req_ready_o  = r_req_ready;
  assign lsu_rvalid_o = r_rvalid;
  assign lsu_rdata_o  = r_rdata;
  assign spurious_o   = r_spurious;

endmodule

// File: tb/tb_lsu_rdata_buf.sv
// Directed bench for lsu_rdata_buf (DEPTH=2): vector table plus async-reset and error sequences.
module tb_lsu_rdata_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_sign, data_rvalid, lsu_rvalid, lsu_rready, spurious;
  logic [1:0]  req_type, req_offset;
  logic [31:0] data_rdata, lsu_rdata;
`ifdef LSU_RDATA_ERR_EN
  logic        data_err, lsu_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_rdata_buf #(.DEPTH(2), .DATA_W(32)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_type_i    (req_type),
    .req_sign_i    (req_sign),
    .req_offset_i  (req_offset),
    .data_rvalid_i (data_rvalid),
    .data_rdata_i  (data_rdata),
`ifdef LSU_RDATA_ERR_EN
    .data_err_i    (data_err),
    .lsu_err_o     (lsu_err),
`endif
    .lsu_rvalid_o  (lsu_rvalid),
    .lsu_rready_i  (lsu_rready),
    .lsu_rdata_o   (lsu_rdata),
    .spurious_o    (spurious)
  );

  typedef struct {
    logic        rq;
    logic [1:0]  typ;
    logic        sgn;
    logic [1:0]  off;
    logic        rv;
    logic [31:0] rd;
    logic        rr;
    logic        e_rdy;
    logic        e_val;
    logic [31:0] e_data;
    logic        e_sp;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs [NV];

  function automatic vec_t mk(logic rq, logic [1:0] typ, logic sgn, logic [1:0] off, logic rv,
                              logic [31:0] rd, logic rr, logic e_rdy, logic e_val,
                              logic [31:0] e_data, logic e_sp);
    vec_t v;
    v.rq = rq; v.typ = typ; v.sgn = sgn; v.off = off; v.rv = rv; v.rd = rd; v.rr = rr;
    v.e_rdy = e_rdy; v.e_val = e_val; v.e_data = e_data; v.e_sp = e_sp;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rq, input logic [1:0] typ, input logic sgn, input logic [1:0] off,
                       input logic rv, input logic [31:0] rd, input logic rr);
    req_valid = rq; req_type = typ; req_sign = sgn; req_offset = off;
    data_rvalid = rv; data_rdata = rd; lsu_rready = rr;
  endtask

  initial begin
    // rq typ sgn off rv rdata rr | ready rvalid rdata spurious (outputs seen before this row's edge)
    vecs[0]  = mk(0, 2'd0, 0, 2'd0, 0, 32'h0,        0, 1, 0, 32'h0,        0);
    vecs[1]  = mk(1, 2'd0, 1, 2'd2, 0, 32'h0,        0, 1, 0, 32'h0,        0);
    vecs[2]  = mk(0, 2'd0, 0, 2'd0, 1, 32'h12803456, 0, 1, 0, 32'h0,        0);
    vecs[3]  = mk(0, 2'd0, 0, 2'd0, 0, 32'h0,        0, 1, 1, 32'hFFFFFF80, 0);
    vecs[4]  = mk(0, 2'd0, 0, 2'd0, 0, 32'h0,        1, 1, 1, 32'hFFFFFF80, 0);
    vecs[5]  = mk(0, 2'd0, 0, 2'd0, 0, 32'h0,        0, 1, 0, 32'hFFFFFF80, 0);
    vecs[6]  = mk(1, 2'd1, 0, 2'd3, 0, 32'h0,        0, 1, 0, 32'hFFFFFF80, 0);
    vecs[7]  = mk(0, 2'd0, 0, 2'd0, 1, 32'hBEEF1234, 0, 1, 0, 32'hFFFFFF80, 0);
    vecs[8]  = mk(0, 2'd0, 0, 2'd0, 0, 32'h0,        1, 1, 1, 32'h0000BEEF, 0);
    vecs[9]  = mk(0, 2'd0, 0, 2'd0, 0, 32'h0,        0, 1, 0, 32'h0000BEEF, 0);
    vecs[10] = mk(1, 2'd0, 0, 2'd0, 0, 32'h0,        0, 1, 0, 32'h0000BEEF, 0);
    vecs[11] = mk(1, 2'd2, 0, 2'd0, 0, 32'h0,        0, 1, 0, 32'h0000BEEF, 0);
    vecs[12] = mk(0, 2'd0, 0, 2'd0, 0, 32'h0,        0, 0, 0, 32'h0000BEEF, 0);
    vecs[13] = mk(1, 2'd2, 0, 2'd0, 0, 32'h0,        0, 0, 0, 32'h0000BEEF, 0);
    vecs[14] = mk(0, 2'd0, 0, 2'd0, 1, 32'h000000A5, 0, 0, 0, 32'h0000BEEF, 0);
    vecs[15] = mk(0, 2'd0, 0, 2'd0, 1, 32'hCAFEF00D, 0, 0, 1, 32'h000000A5, 0);
    vecs[16] = mk(0, 2'd0, 0, 2'd0, 0, 32'h0,        0, 0, 1, 32'h000000A5, 0);
    vecs[17] = mk(0, 2'd0, 0, 2'd0, 0, 32'h0,        1, 0, 1, 32'h000000A5, 0);
    vecs[18] = mk(0, 2'd0, 0, 2'd0, 0, 32'h0,        0, 1, 1, 32'hCAFEF00D, 0);
    vecs[19] = mk(0, 2'd0, 0, 2'd0, 0, 32'h0,        1, 1, 1, 32'hCAFEF00D, 0);
    vecs[20] = mk(0, 2'd0, 0, 2'd0, 0, 32'h0,        0, 1, 0, 32'hCAFEF00D, 0);
    vecs[21] = mk(0, 2'd0, 0, 2'd0, 1, 32'hDEADBEEF, 0, 1, 0, 32'hCAFEF00D, 0);
    vecs[22] = mk(0, 2'd0, 0, 2'd0, 0, 32'h0,        0, 1, 0, 32'hCAFEF00D, 1);
    vecs[23] = mk(0, 2'd0, 0, 2'd0, 0, 32'h0,        0, 1, 0, 32'hCAFEF00D, 0);
    vecs[24] = mk(1, 2'd1, 1, 2'd0, 0, 32'h0,        0, 1, 0, 32'hCAFEF00D, 0);
    vecs[25] = mk(1, 2'd0, 1, 2'd1, 1, 32'h00008001, 0, 1, 0, 32'hCAFEF00D, 0);
    vecs[26] = mk(1, 2'd2, 0, 2'd0, 1, 32'h0000FF00, 1, 0, 1, 32'hFFFF8001, 0);
    vecs[27] = mk(1, 2'd3, 1, 2'd2, 0, 32'h0,        0, 1, 1, 32'hFFFFFFFF, 0);
    vecs[28] = mk(0, 2'd0, 0, 2'd0, 1, 32'h80000000, 1, 0, 1, 32'hFFFFFFFF, 0);
    vecs[29] = mk(0, 2'd0, 0, 2'd0, 0, 32'h0,        1, 1, 1, 32'h80000000, 0);
    vecs[30] = mk(0, 2'd0, 0, 2'd0, 0, 32'h0,        0, 1, 0, 32'h80000000, 0);

    rst_n = 1'b0;
`ifdef LSU_RDATA_ERR_EN
    data_err = 1'b0;
`endif
    drive(0, 2'd0, 0, 2'd0, 0, 32'h0, 0);
    repeat (2) @(negedge clk);
    chk("rst_ready",  -1, 32'(req_ready),  32'd1);
    chk("rst_rvalid", -1, 32'(lsu_rvalid), 32'd0);
    chk("rst_rdata",  -1, lsu_rdata,       32'h0);
    chk("rst_spur",   -1, 32'(spurious),   32'd0);
`ifdef LSU_RDATA_ERR_EN
    chk("rst_err",    -1, 32'(lsu_err),    32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].rq, vecs[i].typ, vecs[i].sgn, vecs[i].off, vecs[i].rv, vecs[i].rd, vecs[i].rr);
      chk("ready",  i, 32'(req_ready),  32'(vecs[i].e_rdy));
      chk("rvalid", i, 32'(lsu_rvalid), 32'(vecs[i].e_val));
      chk("rdata",  i, lsu_rdata,       vecs[i].e_data);
      chk("spur",   i, 32'(spurious),   32'(vecs[i].e_sp));
    end

    // Async reset with two results queued
    @(negedge clk); drive(1, 2'd0, 0, 2'd3, 0, 32'h0, 0);
    @(negedge clk); drive(1, 2'd2, 0, 2'd0, 1, 32'h11223344, 0);
    @(negedge clk); drive(0, 2'd0, 0, 2'd0, 1, 32'h99887766, 0);
    @(negedge clk); drive(0, 2'd0, 0, 2'd0, 0, 32'h0, 0);
    chk("q2_rvalid", 100, 32'(lsu_rvalid), 32'd1);
    chk("q2_rdata",  100, lsu_rdata,       32'h00000011);
    chk("q2_ready",  100, 32'(req_ready),  32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rvalid", 101, 32'(lsu_rvalid), 32'd0);
    chk("arst_ready",  101, 32'(req_ready),  32'd1);
    chk("arst_rdata",  101, lsu_rdata,       32'h0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("post_rvalid", 102 + k, 32'(lsu_rvalid), 32'd0);
      chk("post_ready",  102 + k, 32'(req_ready),  32'd1);
    end
    drive(1, 2'd1, 1, 2'd2, 0, 32'h0, 0);
    @(negedge clk); drive(0, 2'd0, 0, 2'd0, 1, 32'h80001234, 0);
    @(negedge clk); drive(0, 2'd0, 0, 2'd0, 0, 32'h0, 1);
    chk("new_rvalid", 104, 32'(lsu_rvalid), 32'd1);
    chk("new_rdata",  104, lsu_rdata,       32'hFFFF8000);
    @(negedge clk); drive(0, 2'd0, 0, 2'd0, 0, 32'h0, 0);
    chk("drain_rvalid", 105, 32'(lsu_rvalid), 32'd0);

`ifdef LSU_RDATA_ERR_EN
    drive(1, 2'd2, 0, 2'd0, 0, 32'h0, 0);
    @(negedge clk); drive(0, 2'd0, 0, 2'd0, 1, 32'h5555AAAA, 0); data_err = 1'b1;
    @(negedge clk); drive(0, 2'd0, 0, 2'd0, 0, 32'h0, 1); data_err = 1'b0;
    chk("err_rvalid", 106, 32'(lsu_rvalid), 32'd1);
    chk("err_rdata",  106, lsu_rdata,       32'h0);
    chk("err_flag",   106, 32'(lsu_err),    32'd1);
    @(negedge clk); drive(0, 2'd0, 0, 2'd0, 0, 32'h0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
